// File: rtl/eight_queen_pkg.sv
// Shared types and constants for the Eight Queen search engine.
package eight_queen_pkg;

    // Largest board the column register file and board bus can hold.
    localparam int MAX_N = 8;

    // Number of distinct solutions for each supported board size.
    localparam int SOL_COUNT_N4 = 2;
    localparam int SOL_COUNT_N5 = 10;
    localparam int SOL_COUNT_N6 = 4;
    localparam int SOL_COUNT_N7 = 40;
    localparam int SOL_COUNT_N8 = 92;

    // Row and column indices are 3 bits wide.
    typedef logic [2:0] col_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_ACCEPT    = 3'd2,
        ST_ADVANCE   = 3'd3,
        ST_BACKTRACK = 3'd4,
        ST_FOUND     = 3'd5,
        ST_EXHAUSTED = 3'd6
    } solver_state_t;

    // Reference solution count for a board size (0 for unsupported sizes).
    function automatic logic [6:0] expected_solutions(input int n);
        logic [6:0] cnt;
        case (n)
            4:       cnt = 7'(SOL_COUNT_N4);
            5:       cnt = 7'(SOL_COUNT_N5);
            6:       cnt = 7'(SOL_COUNT_N6);
            7:       cnt = 7'(SOL_COUNT_N7);
            8:       cnt = 7'(SOL_COUNT_N8);
            default: cnt = 7'd0;
        endcase
        return cnt;
    endfunction

endpackage

// File: rtl/abs_subtractor.sv
// 3-bit unsigned absolute-difference primitive: diff = |a - b|.
module abs_subtractor (
    input  logic [2:0] a,
    input  logic [2:0] b,
    output logic [2:0] diff
);

    // Subtract the smaller operand from the larger so the result never wraps.
    always_comb begin
        if (a >= b) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
    end

endmodule

// File: rtl/queen_conflict.sv
// Combinational attack test between two queens a known row distance apart.
module queen_conflict (
    input  logic [2:0] col_a,
    input  logic [2:0] col_b,
    input  logic [2:0] row_dist,
    output logic       conflict
);

    logic [2:0] col_dist_s;

    abs_subtractor u_abs (
        .a    (col_a),
        .b    (col_b),
        .diff (col_dist_s)
    );

    // Same column, or the column gap equals the row gap (shared diagonal).
    always_comb begin
        if (col_a == col_b) begin
            conflict = 1'b1;
        end else if (col_dist_s == row_dist) begin
            conflict = 1'b1;
        end else begin
            conflict = 1'b0;
        end
    end

endmodule

// File: rtl/queen_backtrack_solver.sv
// Row-by-row N-Queens backtracking search with a found/next handshake.
// Each candidate is checked against one earlier row per cycle; solutions
// appear in lexicographic order of the row-0, row-1, ... columns.
module queen_backtrack_solver #(
    parameter int N = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        next,
    output logic        busy,
    output logic        found,
    output logic        done,
    output logic [23:0] board,
    output logic [6:0]  sol_count
);

    import eight_queen_pkg::*;

    localparam col_t LAST_IDX = col_t'(N - 1);

    solver_state_t state_r;
    solver_state_t state_next_s;

    col_t        row_r;
    col_t        k_r;
    col_t        cols_r [MAX_N];
    logic [6:0]  sol_count_r;

    logic        busy_r;
    logic        found_r;
    logic        done_r;
    logic [23:0] board_r;

    logic        busy_next_s;
    logic        found_next_s;
    logic        done_next_s;
    logic [23:0] board_next_s;

    col_t        row_dist_s;
    logic        conflict_s;

    // k never exceeds row while checking, so the distance is non-negative.
    assign row_dist_s = row_r - k_r;

    queen_conflict u_conflict (
        .col_a    (cols_r[k_r]),
        .col_b    (cols_r[row_r]),
        .row_dist (row_dist_s),
        .conflict (conflict_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decision for the search.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE, ST_EXHAUSTED: begin
                if (start) begin
                    state_next_s = ST_CHECK;
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_CHECK: begin
                if (k_r == row_r) begin
                    state_next_s = ST_ACCEPT;
                end else if (conflict_s) begin
                    state_next_s = ST_ADVANCE;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_ACCEPT: begin
                if (row_r == LAST_IDX) begin
                    state_next_s = ST_FOUND;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_ADVANCE: begin
                if (cols_r[row_r] == LAST_IDX) begin
                    state_next_s = ST_BACKTRACK;
                end else begin
                    state_next_s = ST_CHECK;
                end
            end
            ST_BACKTRACK: begin
                if (row_r == 3'd0) begin
                    state_next_s = ST_EXHAUSTED;
                end else begin
                    state_next_s = ST_ADVANCE;
                end
            end
            ST_FOUND: begin
                // A fresh start takes priority over resuming.
                if (start) begin
                    state_next_s = ST_CHECK;
                end else if (next) begin
                    state_next_s = ST_ADVANCE;
                end else begin
                    state_next_s = ST_FOUND;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Column register file, row/k cursors and the solution counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            row_r       <= 3'd0;
            k_r         <= 3'd0;
            sol_count_r <= 7'd0;
            for (int r = 0; r < MAX_N; r++) begin
                cols_r[r] <= 3'd0;
            end
        end else begin
            case (state_r)
                ST_IDLE, ST_EXHAUSTED, ST_FOUND: begin
                    if (start) begin
                        row_r       <= 3'd0;
                        k_r         <= 3'd0;
                        sol_count_r <= 7'd0;
                        for (int r = 0; r < MAX_N; r++) begin
                            cols_r[r] <= 3'd0;
                        end
                    end
                end
                ST_CHECK: begin
                    if ((k_r != row_r) && !conflict_s) begin
                        k_r <= k_r + 3'd1;
                    end
                end
                ST_ACCEPT: begin
                    if (row_r == LAST_IDX) begin
                        if (sol_count_r != 7'd127) begin
                            sol_count_r <= sol_count_r + 7'd1;
                        end
                    end else begin
                        row_r                 <= row_r + 3'd1;
                        cols_r[row_r + 3'd1]  <= 3'd0;
                        k_r                   <= 3'd0;
                    end
                end
                ST_ADVANCE: begin
                    if (cols_r[row_r] != LAST_IDX) begin
                        cols_r[row_r] <= cols_r[row_r] + 3'd1;
                        k_r           <= 3'd0;
                    end
                end
                ST_BACKTRACK: begin
                    if (row_r != 3'd0) begin
                        cols_r[row_r] <= 3'd0;
                        row_r         <= row_r - 3'd1;
                    end
                end
                default: begin
                    row_r <= row_r;
                end
            endcase
        end
    end

    // Output values for the state being entered, so outputs track the state register.
    always_comb begin
        busy_next_s  = 1'b0;
        found_next_s = 1'b0;
        done_next_s  = 1'b0;
        board_next_s = 24'd0;
        case (state_next_s)
            ST_CHECK, ST_ACCEPT, ST_ADVANCE, ST_BACKTRACK: begin
                busy_next_s = 1'b1;
            end
            ST_FOUND: begin
                found_next_s = 1'b1;
                for (int r = 0; r < MAX_N; r++) begin
                    if (r < N) begin
                        board_next_s[3*r +: 3] = cols_r[r];
                    end else begin
                        board_next_s[3*r +: 3] = 3'd0;
                    end
                end
            end
            ST_EXHAUSTED: begin
                done_next_s = 1'b1;
            end
            default: begin
                busy_next_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            found_r <= 1'b0;
            done_r  <= 1'b0;
            board_r <= 24'd0;
        end else begin
            busy_r  <= busy_next_s;
            found_r <= found_next_s;
            done_r  <= done_next_s;
            board_r <= board_next_s;
        end
    end

    assign busy      = busy_r;
    assign found     = found_r;
    assign done      = done_r;
    assign board     = board_r;
    assign sol_count = sol_count_r;

endmodule

// File: tb/tb_queen_backtrack_solver.sv
// Scoreboard bench for queen_backtrack_solver at N = 4, 6 and 8.
module tb_queen_backtrack_solver;

    localparam int NI = 3;

    typedef struct packed {
        logic        is_done;
        logic [23:0] board;
        logic [6:0]  cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v   [NI];
    logic        start_v [NI];
    logic        next_v  [NI];
    logic        busy_v  [NI];
    logic        found_v [NI];
    logic        done_v  [NI];
    logic [23:0] board_v [NI];
    logic [6:0]  cnt_v   [NI];

    logic        found_q [NI];
    logic        done_q  [NI];

    exp_t        exp_q [NI][$];
    logic [23:0] sols  [NI][$];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        queen_backtrack_solver #(.N((g == 0) ? 4 : ((g == 1) ? 6 : 8))) u_dut (
            .clk       (clk),
            .rst       (rst_v[g]),
            .start     (start_v[g]),
            .next      (next_v[g]),
            .busy      (busy_v[g]),
            .found     (found_v[g]),
            .done      (done_v[g]),
            .board     (board_v[g]),
            .sol_count (cnt_v[g])
        );
    end

    function automatic int n_of(input int i);
        return (i == 0) ? 4 : ((i == 1) ? 6 : 8);
    endfunction

    function automatic logic [23:0] pack(input int c0, input int c1, input int c2, input int c3,
                                         input int c4, input int c5, input int c6, input int c7);
        logic [23:0] b;
        b = {3'(c7), 3'(c6), 3'(c5), 3'(c4), 3'(c3), 3'(c2), 3'(c1), 3'(c0)};
        return b;
    endfunction

    // Independent rule check: columns in range, distinct, no shared diagonal, unused rows zero.
    function automatic bit legal(input logic [23:0] b, input int n);
        int c [8];
        bit ok;
        ok = 1'b1;
        for (int r = 0; r < 8; r++) c[r] = int'(b[3*r +: 3]);
        for (int r = 0; r < 8; r++) begin
            if (r >= n && c[r] != 0) ok = 1'b0;
            if (r < n && c[r] >= n) ok = 1'b0;
        end
        for (int r = 0; r < n; r++)
            for (int s = r + 1; s < n; s++) begin
                if (c[r] == c[s]) ok = 1'b0;
                if (c[r] - c[s] == s - r || c[s] - c[r] == s - r) ok = 1'b0;
            end
        return ok;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference: every permutation in lexicographic order, kept when no diagonal clash.
    task automatic build_sols(input int i, input int n);
        int  p [8];
        int  j, l, t, lo, hi;
        bit  more;
        logic [23:0] b;
        for (int k = 0; k < 8; k++) p[k] = (k < n) ? k : 0;
        more = 1'b1;
        while (more) begin
            b = 24'd0;
            for (int r = 0; r < n; r++) b[3*r +: 3] = 3'(p[r]);
            if (legal(b, n)) sols[i].push_back(b);
            j = n - 2;
            while (j >= 0 && p[j] > p[j + 1]) j--;
            if (j < 0) begin
                more = 1'b0;
            end else begin
                l = n - 1;
                while (p[l] < p[j]) l--;
                t = p[j]; p[j] = p[l]; p[l] = t;
                lo = j + 1; hi = n - 1;
                while (lo < hi) begin
                    t = p[lo]; p[lo] = p[hi]; p[hi] = t;
                    lo++; hi--;
                end
            end
        end
    endtask

    // Monitor: pop the expected event whenever found or done rises.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < NI; i++) begin
            if (found_v[i] && !found_q[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("found_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    check("event_is_found", {31'd0, e.is_done}, 32'd0);
                    check("found_board", {8'd0, board_v[i]}, {8'd0, e.board});
                    check("found_count", {25'd0, cnt_v[i]}, {25'd0, e.cnt});
                    check("found_busy", {31'd0, busy_v[i]}, 32'd0);
                    check("board_legal", {31'd0, legal(board_v[i], n_of(i))}, 32'd1);
                end
            end
            if (done_v[i] && !done_q[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("done_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q[i].pop_front();
                    check("event_is_done", {31'd0, e.is_done}, 32'd1);
                    check("done_count", {25'd0, cnt_v[i]}, {25'd0, e.cnt});
                    check("done_busy", {31'd0, busy_v[i]}, 32'd0);
                    check("done_board", {8'd0, board_v[i]}, 32'd0);
                end
            end
            found_q[i] = found_v[i];
            done_q[i]  = done_v[i];
        end
    end

    // Wait for found or done, optionally firing stray next pulses while busy.
    task automatic wait_evt(input int i, input bit stray);
        int  n;
        bit  hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < 20000) begin
            @(negedge clk);
            start_v[i] = 1'b0;
            next_v[i]  = 1'b0;
            n++;
            if (found_v[i] || done_v[i]) hit = 1'b1;
            else if (stray && busy_v[i] && $urandom_range(0, 15) == 0) next_v[i] = 1'b1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL wait_timeout instance=%0d actual=no_event required=found_or_done", i);
        end
    endtask

    task automatic run_full(input int i, input logic [23:0] first_ref);
        int total;
        total = sols[i].size();
        exp_q[i].delete();
        start_v[i] = 1'b1;
        exp_q[i].push_back({1'b0, sols[i][0], 7'd1});
        wait_evt(i, 1'b1);
        check("first_solution", {8'd0, board_v[i]}, {8'd0, first_ref});
        for (int s = 1; s <= total; s++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if (s < total) exp_q[i].push_back({1'b0, sols[i][s], 7'(s + 1)});
            else           exp_q[i].push_back({1'b1, 24'd0, 7'(total)});
            next_v[i] = 1'b1;
            wait_evt(i, 1'b1);
        end
        check("run_done", {31'd0, done_v[i]}, 32'd1);
        check("run_total", {25'd0, cnt_v[i]}, 32'(total));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; next_v[i] = 1'b0;
            found_q[i] = 1'b0; done_q[i] = 1'b0;
            build_sols(i, n_of(i));
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            rst_v[i] = 1'b0;
            check("reset_busy",  {31'd0, busy_v[i]},  32'd0);
            check("reset_found", {31'd0, found_v[i]}, 32'd0);
            check("reset_done",  {31'd0, done_v[i]},  32'd0);
            check("reset_board", {8'd0, board_v[i]},  32'd0);
            check("reset_count", {25'd0, cnt_v[i]},   32'd0);
        end

        // next in IDLE has no effect
        next_v[0] = 1'b1;
        @(negedge clk);
        next_v[0] = 1'b0;
        @(negedge clk);
        check("idle_next_busy",  {31'd0, busy_v[0]},  32'd0);
        check("idle_next_found", {31'd0, found_v[0]}, 32'd0);

        // reset in the middle of a search
        start_v[2] = 1'b1;
        @(negedge clk);
        start_v[2] = 1'b0;
        repeat ($urandom_range(5, 30)) @(negedge clk);
        check("mid_busy", {31'd0, busy_v[2]}, 32'd1);
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        check("abort_busy",  {31'd0, busy_v[2]},  32'd0);
        check("abort_found", {31'd0, found_v[2]}, 32'd0);
        check("abort_done",  {31'd0, done_v[2]},  32'd0);
        check("abort_board", {8'd0, board_v[2]},  32'd0);
        check("abort_count", {25'd0, cnt_v[2]},   32'd0);
        repeat (3) @(negedge clk);
        check("abort_stays_idle", {31'd0, busy_v[2]}, 32'd0);

        run_full(0, pack(1, 3, 0, 2, 0, 0, 0, 0));
        run_full(1, pack(1, 3, 5, 0, 2, 4, 0, 0));

        // restart after exhaustion: done clears, first solution recurs
        start_v[1] = 1'b1;
        exp_q[1].push_back({1'b0, sols[1][0], 7'd1});
        wait_evt(1, 1'b0);
        check("restart_done_clear", {31'd0, done_v[1]}, 32'd0);
        check("restart_board", {8'd0, board_v[1]}, {8'd0, pack(1, 3, 5, 0, 2, 4, 0, 0)});

        run_full(2, pack(0, 4, 7, 5, 2, 6, 1, 3));

        // start and next together while a solution is held: start wins
        start_v[2] = 1'b1;
        exp_q[2].push_back({1'b0, sols[2][0], 7'd1});
        wait_evt(2, 1'b0);
        next_v[2] = 1'b1;
        exp_q[2].push_back({1'b0, sols[2][1], 7'd2});
        wait_evt(2, 1'b0);
        start_v[2] = 1'b1;
        next_v[2]  = 1'b1;
        exp_q[2].push_back({1'b0, sols[2][0], 7'd1});
        wait_evt(2, 1'b0);
        check("start_wins_count", {25'd0, cnt_v[2]}, 32'd1);

        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check("queue_drained", 32'(exp_q[i].size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
